// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - fetch/decode shared types and constants
package fetch_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    function automatic logic [6:0] inst_opcode(input logic [31:0] inst);
        return inst[6:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush and occupancy count
// Used for both the instruction buffer and the in-flight PC queue.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop & (r_count != '0);
    assign w_push  = i_push & (~w_full | w_pop);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch_stage.sv
// rtl/inst_fetch_stage.sv - instruction fetch: PC, credit-limited imem requests, decode buffer
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module inst_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int UW = CW + 1;

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_stale;
    logic [CW-1:0]   w_stale_next;

    logic [CW-1:0]   w_if_count;
    logic [CW-1:0]   w_ib_count;
    logic            w_if_empty;
    logic            w_ib_empty;
    logic [31:0]     w_if_head;
    logic [63:0]     w_ib_head;
    logic [UW-1:0]   w_used;
    logic            w_deq;
    logic            w_credit;
    logic            w_req_fire;
    logic            w_rsp_take;
    logic            w_ib_push;
    logic [31:0]     w_redirect_aligned;

    assign w_redirect_aligned = redirect_pc & ~32'h3;
    assign w_deq      = ~w_ib_empty & id_ready;
    assign w_used     = UW'(w_if_count) + UW'(w_ib_count) - UW'(w_deq);
    assign w_credit   = (w_used < UW'(FIFO_DEPTH));

    // Gated by rst_n so the request drops the moment reset is asserted.
    assign imem_req_valid = rst_n & (r_state == FETCH) & w_credit & ~redirect_valid;
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;

    // The in-flight queue is empty in FLUSH, so only live responses are taken here.
    assign w_rsp_take = imem_rsp_valid & ~w_if_empty;
    assign w_ib_push  = w_rsp_take & ~redirect_valid;

    assign id_valid = ~w_ib_empty;
    assign id_pc    = id_valid ? w_ib_head[63:32] : 32'h0;
    assign id_inst  = id_valid ? w_ib_head[31:0]  : 32'h0;

    fetch_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_inflight (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_req_fire),
        .i_data  (r_pc),
        .i_pop   (w_rsp_take),
        .i_flush (redirect_valid),
        .o_head  (w_if_head),
        .o_count (w_if_count),
        .o_empty (w_if_empty)
    );

    fetch_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_ibuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_ib_push),
        .i_data  ({w_if_head, imem_rsp_data}),
        .i_pop   (w_deq),
        .i_flush (redirect_valid),
        .o_head  (w_ib_head),
        .o_count (w_ib_count),
        .o_empty (w_ib_empty)
    );

    always_comb begin
        w_stale_next = r_stale;
        w_state_next = r_state;
        if (redirect_valid) begin
            if (r_state == FLUSH) begin
                w_stale_next = r_stale - CW'(imem_rsp_valid && (r_stale != '0));
            end else begin
                w_stale_next = w_if_count - CW'(w_rsp_take);
            end
            w_state_next = (w_stale_next != '0) ? FLUSH : FETCH;
        end else if (r_state == FLUSH && imem_rsp_valid && r_stale != '0) begin
            w_stale_next = r_stale - CW'(1);
            w_state_next = (w_stale_next == '0) ? FETCH : FLUSH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_state <= FETCH;
            r_stale <= '0;
        end else begin
            r_state <= w_state_next;
            r_stale <= w_stale_next;
            if (redirect_valid) begin
                r_pc <= w_redirect_aligned;
            end else if (w_req_fire) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= 32'h0;
            r_perf_stall   <= 32'h0;
        end else begin
            if (w_deq) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (r_state == FETCH && !w_credit) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_inst_fetch_stage.sv
// tb/tb_inst_fetch_stage.sv - randomized self-checking bench for inst_fetch_stage
module tb_inst_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    inst_fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_inst        (id_inst)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;

    mreq_t       mq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc;
    int          accepted;
    int          handshakes;
    int          stall_model;
    int          first_valid_cyc;
    bit          any_redir;
    bit          prev_hold;
    bit          prev_redir;
    bit          did_redir;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;

    int          lat_min = 1;
    int          lat_max = 1;
    int          rdy_pct = 100;
    int          idr_pct = 100;
    int          redir_permil = 0;
    bit          force_redir = 1'b0;
    bit          redir_on_rsp = 1'b0;
    logic [31:0] redir_target = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_id_valid", 32'(id_valid), 32'd0);
        check_eq("rst_id_pc", id_pc, 32'h0);
        check_eq("rst_id_inst", id_inst, 32'h0);
        mq.delete();
        exp_pc          = RESET_PC;
        exp_req         = RESET_PC;
        accepted        = 0;
        handshakes      = 0;
        stall_model     = 0;
        first_valid_cyc = -1;
        any_redir       = 1'b0;
        prev_hold       = 1'b0;
        prev_redir      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = 32'h0;
        imem_req_ready  = 1'b0;
        id_ready        = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // One cycle: drive at the falling edge, sample 1 time unit later, commit at the rising edge.
    task automatic step();
        mreq_t h;
        bit    do_redir;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            h = mq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(h.addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        id_ready       = (int'($urandom_range(99)) < idr_pct);
        imem_req_ready = (int'($urandom_range(99)) < rdy_pct);
        if (!force_redir && !redir_on_rsp) redir_target = $urandom;
        do_redir = force_redir || (redir_on_rsp && imem_rsp_valid)
                   || (int'($urandom_range(999)) < redir_permil);
        redirect_valid = do_redir;
        redirect_pc    = do_redir ? redir_target : $urandom;
        #1;
        if (prev_redir) begin
            check_eq("id_valid_after_redirect", 32'(id_valid), 32'd0);
        end else if (prev_hold) begin
            check_eq("hold_valid", 32'(id_valid), 32'd1);
            check_eq("hold_pc", id_pc, hold_pc);
            check_eq("hold_inst", id_inst, hold_inst);
        end
`ifdef FETCH_PERF_CNT_EN
        check_eq("perf_fetched", perf_fetched, 32'(handshakes));
        if (!any_redir) check_eq("perf_stall", perf_stall, 32'(stall_model));
`endif
        if (id_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (id_valid && id_ready) begin
            check_eq("id_pc", id_pc, exp_pc);
            check_eq("id_inst", id_inst, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            handshakes++;
        end
        if (!any_redir && !imem_req_valid) stall_model++;
        if (redirect_valid) check_eq("req_during_redirect", 32'(imem_req_valid), 32'd0);
        if (imem_req_valid && imem_req_ready) begin
            check_eq("req_addr", imem_req_addr, exp_req);
            exp_req = exp_req + 32'd4;
            accepted++;
            mq.push_back('{cyc + int'($urandom_range(lat_max, lat_min)), imem_req_addr});
            check_eq("outstanding_le_depth", 32'(mq.size() <= DEPTH), 32'd1);
        end
        prev_hold  = id_valid && !id_ready && !redirect_valid;
        hold_pc    = id_pc;
        hold_inst  = id_inst;
        prev_redir = redirect_valid;
        if (redirect_valid) begin
            exp_pc    = redir_target & ~32'h3;
            exp_req   = redir_target & ~32'h3;
            any_redir = 1'b1;
            did_redir = 1'b1;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic redirect_now(input logic [31:0] target);
        redir_target = target;
        force_redir  = 1'b1;
        step();
        force_redir  = 1'b0;
    endtask

    initial begin
        int hs_mark;
        rst_n = 1'b0;
        @(negedge clk);
        do_reset();

        // Fill latency and full-rate streaming
        repeat (10) step();
        check_eq("first_valid_cycle", 32'(first_valid_cyc), 32'd2);
        check_eq("stream_handshakes", 32'(handshakes), 32'd8);

        // Decode back-pressure: buffer plus in-flight fills to exactly the depth
        idr_pct = 0;
        repeat (5) step();
        check_eq("backpressure_fill", 32'(accepted - handshakes), 32'(DEPTH));
        idr_pct = 100;
        repeat (6) step();

        // Redirect with two fetches outstanding
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 50 && mq.size() != 2; i++) step();
        check_eq("two_inflight_reached", 32'(mq.size()), 32'd2);
        redirect_now(32'h0000_0100);
        hs_mark = handshakes;
        repeat (10) step();
        check_eq("progress_after_redirect", 32'(handshakes > hs_mark), 32'd1);

        // Misaligned redirect target
        lat_min = 1; lat_max = 1;
        redirect_now(32'h0000_0203);
        repeat (8) step();

        // Redirect landing on a response cycle
        did_redir    = 1'b0;
        redir_target = 32'h0000_0400;
        redir_on_rsp = 1'b1;
        for (int i = 0; i < 30 && !did_redir; i++) step();
        redir_on_rsp = 1'b0;
        check_eq("redirect_on_rsp_done", 32'(did_redir), 32'd1);
        repeat (8) step();

        // Address wrap at the top of the space
        redirect_now(32'hFFFF_FFFC);
        hs_mark = handshakes;
        repeat (8) step();
        check_eq("wrap_progress", 32'(handshakes - hs_mark >= 3), 32'd1);

        // Reset in the middle of a burst
        rdy_pct = 70; idr_pct = 60; lat_max = 3;
        repeat (7) step();
        do_reset();
        rdy_pct = 100; idr_pct = 100; lat_min = 1; lat_max = 1;
        repeat (8) step();
        check_eq("restart_first_valid", 32'(first_valid_cyc), 32'd2);

        // Randomized traffic
        redir_permil = 25;
        for (int blk = 0; blk < 30; blk++) begin
            rdy_pct = int'($urandom_range(100, 30));
            idr_pct = int'($urandom_range(100, 20));
            lat_min = 1;
            lat_max = int'($urandom_range(4, 1));
            repeat (100) step();
        end
        redir_permil = 0;
        check_eq("random_progress", 32'(handshakes > 300), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
